// File: rtl/receptor_mdio.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : receptor_mdio                                                |
// | Description : MDIO frame receiver on MDC; decodes 32-bit frames into       |
// |               register writes and serialised register reads.               |
// |               Optional macro MDIO_PHYAD_CHECK_EN filters on PHY_ADDR.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module receptor_mdio #(
    parameter logic [4:0] PHY_ADDR = 5'b00000
) (
    input  logic        MDC,
    input  logic        reset,
    input  logic        MDIO_OUT,
    input  logic        MDIO_OE,
    input  logic [0:15] RD_DATA,
    output logic        MDIO_IN,
    output logic [0:4]  ADDR,
    output logic [0:15] WR_DATA,
    output logic        MDIO_DONE,
    output logic        WR_STB
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_START  = 4'd1,
        S_OPCODE = 4'd2,
        S_PHYAD  = 4'd3,
        S_REGAD  = 4'd4,
        S_TA     = 4'd5,
        S_WDATA  = 4'd6,
        S_RDATA  = 4'd7,
        S_DONE   = 4'd8
    } state_t;

    state_t      state_q,   state_d;
    logic [4:0]  cnt_q,     cnt_d;
    logic        op_hi_q,   op_hi_d;
    logic        rd_q,      rd_d;
    logic [3:0]  phy_q,     phy_d;
    logic [3:0]  reg_q,     reg_d;
    logic [14:0] wr_sr_q,   wr_sr_d;
    logic [0:15] rd_sr_q,   rd_sr_d;
    logic        mdio_in_q, mdio_in_d;
    logic [0:4]  addr_q,    addr_d;
    logic [0:15] wr_data_q, wr_data_d;
    logic        done_q,    done_d;
    logic        wr_stb_q,  wr_stb_d;

    logic [1:0]  w_op_now;
    logic [4:0]  w_phy_now;
    logic        w_phy_ok;
    logic        w_need_oe;

    assign w_op_now  = {op_hi_q, MDIO_OUT};
    assign w_phy_now = {phy_q, MDIO_OUT};
    // Controller must own the line for header bits and write data; read data time is ours.
    assign w_need_oe = (state_q != S_IDLE) && (state_q != S_RDATA) && (state_q != S_DONE);

`ifdef MDIO_PHYAD_CHECK_EN
    assign w_phy_ok = (w_phy_now == PHY_ADDR);
`else
    logic w_unused_phy;
    assign w_unused_phy = ^{w_phy_now, PHY_ADDR};
    assign w_phy_ok     = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 5'd1;
        op_hi_d   = op_hi_q;
        rd_d      = rd_q;
        phy_d     = phy_q;
        reg_d     = reg_q;
        wr_sr_d   = wr_sr_q;
        rd_sr_d   = rd_sr_q;
        mdio_in_d = 1'b0;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        wr_stb_d  = 1'b0;

        if (w_need_oe && !MDIO_OE) begin
            state_d = S_IDLE;
            cnt_d   = 5'd0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    cnt_d = 5'd0;
                    if (MDIO_OE && !MDIO_OUT) begin
                        state_d = S_START;
                        cnt_d   = 5'd1;
                    end
                end
                S_START: begin
                    if (MDIO_OUT) begin
                        state_d = S_OPCODE;
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = 5'd0;
                    end
                end
                S_OPCODE: begin
                    if (cnt_q == 5'd2) begin
                        op_hi_d = MDIO_OUT;
                    end else begin
                        rd_d = (w_op_now == 2'b10);
                        if (w_op_now == 2'b01 || w_op_now == 2'b10) begin
                            state_d = S_PHYAD;
                        end else begin
                            state_d = S_IDLE;
                            cnt_d   = 5'd0;
                        end
                    end
                end
                S_PHYAD: begin
                    phy_d = w_phy_now[3:0];
                    if (cnt_q == 5'd8) begin
                        if (w_phy_ok) begin
                            state_d = S_REGAD;
                        end else begin
                            state_d = S_IDLE;
                            cnt_d   = 5'd0;
                        end
                    end
                end
                S_REGAD: begin
                    reg_d = {reg_q[2:0], MDIO_OUT};
                    if (cnt_q == 5'd13) begin
                        addr_d  = {reg_q, MDIO_OUT};
                        state_d = S_TA;
                    end
                end
                S_TA: begin
                    if (cnt_q == 5'd15) begin
                        if (rd_q) begin
                            rd_sr_d   = {RD_DATA[1:15], 1'b0};
                            mdio_in_d = RD_DATA[0];
                            state_d   = S_RDATA;
                        end else begin
                            state_d = S_WDATA;
                        end
                    end
                end
                S_WDATA: begin
                    wr_sr_d = {wr_sr_q[13:0], MDIO_OUT};
                    if (cnt_q == 5'd31) begin
                        wr_data_d = {wr_sr_q, MDIO_OUT};
                        wr_stb_d  = 1'b1;
                        done_d    = 1'b1;
                        state_d   = S_DONE;
                    end
                end
                S_RDATA: begin
                    if (cnt_q == 5'd31) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        mdio_in_d = rd_sr_q[0];
                        rd_sr_d   = {rd_sr_q[1:15], 1'b0};
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    cnt_d   = 5'd0;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = 5'd0;
                end
            endcase
        end
    end

    always_ff @(posedge MDC) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 5'd0;
            op_hi_q   <= 1'b0;
            rd_q      <= 1'b0;
            phy_q     <= 4'd0;
            reg_q     <= 4'd0;
            wr_sr_q   <= 15'd0;
            rd_sr_q   <= 16'd0;
            mdio_in_q <= 1'b0;
            addr_q    <= 5'd0;
            wr_data_q <= 16'd0;
            done_q    <= 1'b0;
            wr_stb_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_hi_q   <= op_hi_d;
            rd_q      <= rd_d;
            phy_q     <= phy_d;
            reg_q     <= reg_d;
            wr_sr_q   <= wr_sr_d;
            rd_sr_q   <= rd_sr_d;
            mdio_in_q <= mdio_in_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            wr_stb_q  <= wr_stb_d;
        end
    end

    assign MDIO_IN   = mdio_in_q;
    assign ADDR      = addr_q;
    assign WR_DATA   = wr_data_q;
    assign MDIO_DONE = done_q;
    assign WR_STB    = wr_stb_q;

endmodule
`default_nettype wire

// File: tb/tb_receptor_mdio.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_receptor_mdio                                             |
// | Description : Randomised frame bench for receptor_mdio with a per-bit      |
// |               expectation model derived from the frame rules.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_receptor_mdio;

    localparam logic [4:0] C_PHY = 5'd1;

    logic        MDC;
    logic        reset;
    logic        MDIO_OUT;
    logic        MDIO_OE;
    logic [15:0] RD_DATA;
    logic        MDIO_IN;
    logic [4:0]  ADDR;
    logic [15:0] WR_DATA;
    logic        MDIO_DONE;
    logic        WR_STB;

    int          n_total;
    int          n_bad;
    logic [4:0]  exp_addr;
    logic [15:0] exp_wr_data;

    receptor_mdio #(.PHY_ADDR(C_PHY)) u_dut (
        .MDC      (MDC),
        .reset    (reset),
        .MDIO_OUT (MDIO_OUT),
        .MDIO_OE  (MDIO_OE),
        .RD_DATA  (RD_DATA),
        .MDIO_IN  (MDIO_IN),
        .ADDR     (ADDR),
        .WR_DATA  (WR_DATA),
        .MDIO_DONE(MDIO_DONE),
        .WR_STB   (WR_STB)
    );

    initial MDC = 1'b0;
    always #5 MDC = ~MDC;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string where, input logic e_in, input logic e_done, input logic e_stb);
        check_val({where, " mdio_in"}, {31'd0, MDIO_IN}, {31'd0, e_in});
        check_val({where, " done"}, {31'd0, MDIO_DONE}, {31'd0, e_done});
        check_val({where, " wr_stb"}, {31'd0, WR_STB}, {31'd0, e_stb});
        check_val({where, " addr"}, {27'd0, ADDR}, {27'd0, exp_addr});
        check_val({where, " wr_data"}, {16'd0, WR_DATA}, {16'd0, exp_wr_data});
    endtask

    // One bit per MDC period: inputs change on the falling edge, outputs looked at 1 time unit after the rising edge.
    task automatic drive_edge(input logic oe, input logic out);
        @(negedge MDC);
        reset    = 1'b0;
        MDIO_OE  = oe;
        MDIO_OUT = out;
        @(posedge MDC);
        #1;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 1) == 1) drive_edge(1'b1, 1'b1);
            else drive_edge(1'b0, 1'($urandom_range(0, 1)));
            check_outs("gap", 1'b0, 1'b0, 1'b0);
        end
    endtask

    // abort_k: bit where the controller drops OE (-1 none); reset_k: bit replaced by a reset pulse (-1 none);
    // full: keep driving an invalid-opcode frame to its end instead of truncating it.
    task automatic run_frame(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] reg_a,
                             input logic [15:0] data, input logic [15:0] rd,
                             input int abort_k, input int reset_k, input bit full);
        logic [31:0] fr;
        bit          ok_op;
        bit          ok_phy;
        bit          is_rd;
        bit          live;
        logic        e_in;
        logic        e_done;
        logic        e_stb;
        string       where;
        ok_op = (op == 2'b01) || (op == 2'b10);
        is_rd = (op == 2'b10);
`ifdef MDIO_PHYAD_CHECK_EN
        ok_phy = (phy == C_PHY);
`else
        ok_phy = 1'b1;
`endif
        fr = {2'b01, op, phy, reg_a, (is_rd ? 2'b00 : 2'b10), data};
        RD_DATA = rd;
        for (int k = 0; k < 32; k++) begin
            where = $sformatf("op%0d k%0d", op, k);
            if (!full && ((!ok_op && k >= 4) || (!ok_phy && k >= 9))) return;
            if (k == reset_k) begin
                @(negedge MDC);
                reset   = 1'b1;
                MDIO_OE = 1'b0;
                @(posedge MDC);
                #1;
                exp_addr    = 5'd0;
                exp_wr_data = 16'd0;
                check_outs({where, " reset"}, 1'b0, 1'b0, 1'b0);
                return;
            end
            if (k == abort_k) begin
                drive_edge(1'b0, 1'($urandom_range(0, 1)));
                check_outs({where, " oe_drop"}, 1'b0, 1'b0, 1'b0);
                return;
            end
            if (is_rd && k >= 16) drive_edge(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else drive_edge(1'b1, fr[31-k]);
            live = (ok_op || k < 3) && (ok_phy || k < 8);
            if (live && k == 13) exp_addr = reg_a;
            e_in   = (live && is_rd && k >= 15 && k <= 30) ? rd[15-(k-15)] : 1'b0;
            e_done = live && (k == 31);
            e_stb  = e_done && !is_rd;
            if (e_stb) exp_wr_data = data;
            check_outs(where, e_in, e_done, e_stb);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  r_op;
        logic [4:0]  r_phy;
        int          r_abort;
        n_total     = 0;
        n_bad       = 0;
        exp_addr    = 5'd0;
        exp_wr_data = 16'd0;
        reset       = 1'b1;
        MDIO_OE     = 1'b0;
        MDIO_OUT    = 1'b0;
        RD_DATA     = 16'd0;
        repeat (2) @(posedge MDC);
        #1;
        check_outs("reset", 1'b0, 1'b0, 1'b0);
        gap(3);

        run_frame(2'b01, C_PHY, 5'd5, 16'hA5C3, 16'h0000, -1, -1, 1'b0);
        gap(3);
        run_frame(2'b10, C_PHY, 5'd10, 16'h0000, 16'h1234, -1, -1, 1'b0);
        gap(3);
        run_frame(2'b11, 5'd31, 5'd31, 16'hFFFF, 16'h0000, -1, -1, 1'b1);
        gap(3);
        run_frame(2'b01, C_PHY, 5'd7, 16'h5A5A, 16'h0000, 20, -1, 1'b0);
        gap(2);
        run_frame(2'b01, C_PHY, 5'd8, 16'hC0DE, 16'h0000, -1, -1, 1'b0);
        gap(2);
        run_frame(2'b01, C_PHY, 5'd9, 16'h1357, 16'h0000, -1, 24, 1'b0);
        gap(2);
        run_frame(2'b01, C_PHY, 5'd3, 16'h0F0F, 16'h0000, -1, -1, 1'b0);
        gap(2);
        run_frame(2'b01, 5'd2, 5'd4, 16'hBEEF, 16'h0000, -1, -1, 1'b0);
        gap(2);
        run_frame(2'b01, C_PHY, 5'd4, 16'hBEEF, 16'h0000, -1, -1, 1'b0);
        gap(2);

        for (int f = 0; f < 80; f++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 5) r_op = 2'b01;
            else if (sel < 9) r_op = 2'b10;
            else r_op = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
`ifdef MDIO_PHYAD_CHECK_EN
            r_phy = ($urandom_range(0, 3) == 0) ? 5'($urandom) : C_PHY;
`else
            r_phy = 5'($urandom);
`endif
            if ($urandom_range(0, 4) == 0) r_abort = $urandom_range(0, (r_op == 2'b10) ? 15 : 31);
            else r_abort = -1;
            run_frame(r_op, r_phy, 5'($urandom), 16'($urandom), 16'($urandom), r_abort, -1, 1'b0);
            gap($urandom_range(2, 5));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
